// File: rtl/ipsxe_floating_point_classify_pkg.sv
// Shared IEEE-754 class encodings and constant-ROM addresses.
// Also used by the constant ROM so both sides agree on addressing.
package ipsxe_floating_point_classify_pkg;

  typedef enum logic [2:0] {
    CLS_NORM = 3'd0,
    CLS_ZERO = 3'd1,
    CLS_SUBN = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } fp_class_e;

  localparam logic [3:0] ROM_ADDR_NONE = 4'd0;
  localparam logic [3:0] ROM_ADDR_INF  = 4'd1;
  localparam logic [3:0] ROM_ADDR_ZERO = 4'd2;
  localparam logic [3:0] ROM_ADDR_NAN  = 4'd3;

  typedef struct packed {
    logic exp_max;
    logic exp_zero;
    logic man_zero;
    logic man_msb;
  } fp_flags_t;

  function automatic fp_class_e fp_classify(
    input fp_flags_t f,
    input logic      ftz
  );
    fp_class_e c;
    c = CLS_NORM;
    if (f.exp_max) begin
      if (f.man_zero)     c = CLS_INF;
      else if (f.man_msb) c = CLS_QNAN;
      else                c = CLS_SNAN;
    end else if (f.exp_zero) begin
      if (f.man_zero || ftz) c = CLS_ZERO;
      else                   c = CLS_SUBN;
    end
    return c;
  endfunction

  // Only +inf lives in the table, so -inf passes through untouched.
  function automatic logic [3:0] fp_rom_addr(
    input fp_class_e c,
    input logic      sign
  );
    logic [3:0] a;
    a = ROM_ADDR_NONE;
    case (c)
      CLS_INF:  a = sign ? ROM_ADDR_NONE : ROM_ADDR_INF;
      CLS_ZERO: a = ROM_ADDR_ZERO;
      CLS_QNAN: a = ROM_ADDR_NAN;
      CLS_SNAN: a = ROM_ADDR_NAN;
      default:  a = ROM_ADDR_NONE;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_sat_cnt.sv
// Saturating event counter with synchronous clear.
// Clear wins over increment.
module ipsxe_floating_point_sat_cnt #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_classify.sv
// Two-stage streaming IEEE-754 classifier: operand -> class and
// constant-ROM address, plus saturating special-value counters.
module ipsxe_floating_point_classify
  import ipsxe_floating_point_classify_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int FTZ       = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   s_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   m_data,
  output logic [2:0]                     m_class,
  output logic                           m_sign,
  output logic                           m_subst,
  output logic [3:0]                     m_rom_addr,
  input  logic                           cnt_clr,
  output logic [CNT_WIDTH-1:0]           cnt_nan,
  output logic [CNT_WIDTH-1:0]           cnt_inf,
  output logic [CNT_WIDTH-1:0]           cnt_zero
);

  localparam int W = 1 + EXP_WIDTH + MAN_WIDTH;

  logic                 s1_valid;
  logic [W-1:0]         s1_data;
  fp_flags_t            s1_flags;
  fp_flags_t            in_flags;
  logic                 s2_load;
  fp_class_e            dec_class;
  logic [3:0]           dec_addr;
  logic [EXP_WIDTH-1:0] in_exp;
  logic [MAN_WIDTH-1:0] in_man;
  logic                 take;
  logic                 inc_nan;
  logic                 inc_inf;
  logic                 inc_zero;

  assign in_exp = s_data[W-2 -: EXP_WIDTH];
  assign in_man = s_data[MAN_WIDTH-1:0];

  always_comb begin
    in_flags          = '0;
    in_flags.exp_max  = &in_exp;
    in_flags.exp_zero = ~|in_exp;
    in_flags.man_zero = ~|in_man;
    in_flags.man_msb  = in_man[MAN_WIDTH-1];
  end

  assign s2_load = !m_valid || m_ready;
  assign s_ready = !s1_valid || s2_load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_flags <= '0;
    end else if (s_ready) begin
      s1_valid <= s_valid;
      if (s_valid) begin
        s1_data  <= s_data;
        s1_flags <= in_flags;
      end
    end
  end

  always_comb begin
    dec_class = fp_classify(s1_flags, FTZ != 0);
    dec_addr  = fp_rom_addr(dec_class, s1_data[W-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_class    <= 3'd0;
      m_sign     <= 1'b0;
      m_subst    <= 1'b0;
      m_rom_addr <= ROM_ADDR_NONE;
    end else if (s2_load) begin
      m_valid <= s1_valid;
      if (s1_valid) begin
        m_data     <= s1_data;
        m_class    <= dec_class;
        m_sign     <= s1_data[W-1];
        m_subst    <= (dec_addr != ROM_ADDR_NONE);
        m_rom_addr <= dec_addr;
      end
    end
  end

  assign take     = m_valid && m_ready;
  assign inc_nan  = take && (m_class == CLS_QNAN ||
                             m_class == CLS_SNAN);
  assign inc_inf  = take && (m_class == CLS_INF);
  assign inc_zero = take && (m_class == CLS_ZERO);

  ipsxe_floating_point_sat_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cnt_nan (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (inc_nan),
    .clr  (cnt_clr),
    .cnt  (cnt_nan)
  );

  ipsxe_floating_point_sat_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cnt_inf (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (inc_inf),
    .clr  (cnt_clr),
    .cnt  (cnt_inf)
  );

  ipsxe_floating_point_sat_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cnt_zero (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (inc_zero),
    .clr  (cnt_clr),
    .cnt  (cnt_zero)
  );

endmodule

// File: tb/tb_ipsxe_floating_point_classify.sv
// Directed bench for the streaming classifier: default, FTZ and
// narrow-counter instances share one stimulus stream.
module tb_ipsxe_floating_point_classify;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [31:0] s_data;
  logic        m_ready;
  logic        cnt_clr;

  logic        s_ready, m_valid, m_sign, m_subst;
  logic [31:0] m_data;
  logic [2:0]  m_class;
  logic [3:0]  m_rom_addr;
  logic [15:0] cnt_nan, cnt_inf, cnt_zero;

  logic        f_s_ready, f_m_valid, f_m_sign, f_m_subst;
  logic [31:0] f_m_data;
  logic [2:0]  f_m_class;
  logic [3:0]  f_m_rom_addr;
  logic [15:0] f_cnt_nan, f_cnt_inf, f_cnt_zero;

  logic        c_s_ready, c_m_valid, c_m_sign, c_m_subst;
  logic [31:0] c_m_data;
  logic [2:0]  c_m_class;
  logic [3:0]  c_m_rom_addr;
  logic [1:0]  c_cnt_nan, c_cnt_inf, c_cnt_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ipsxe_floating_point_classify u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_class(m_class), .m_sign(m_sign), .m_subst(m_subst),
    .m_rom_addr(m_rom_addr), .cnt_clr(cnt_clr),
    .cnt_nan(cnt_nan), .cnt_inf(cnt_inf), .cnt_zero(cnt_zero)
  );

  ipsxe_floating_point_classify #(.FTZ(1)) u_ftz (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(f_s_ready), .s_data(s_data),
    .m_valid(f_m_valid), .m_ready(m_ready), .m_data(f_m_data),
    .m_class(f_m_class), .m_sign(f_m_sign), .m_subst(f_m_subst),
    .m_rom_addr(f_m_rom_addr), .cnt_clr(cnt_clr),
    .cnt_nan(f_cnt_nan), .cnt_inf(f_cnt_inf), .cnt_zero(f_cnt_zero)
  );

  ipsxe_floating_point_classify #(.CNT_WIDTH(2)) u_cnt (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(c_s_ready), .s_data(s_data),
    .m_valid(c_m_valid), .m_ready(m_ready), .m_data(c_m_data),
    .m_class(c_m_class), .m_sign(c_m_sign), .m_subst(c_m_subst),
    .m_rom_addr(c_m_rom_addr), .cnt_clr(cnt_clr),
    .cnt_nan(c_cnt_nan), .cnt_inf(c_cnt_inf), .cnt_zero(c_cnt_zero)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] data;
    logic [2:0]  cls;
    logic [3:0]  addr;
    logic        subst;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] exp_q[$];
  logic [31:0] got, want;
  int sent, rcvd;
  bit exp_rdy[6];

  initial begin
    vecs[0] = '{32'h3F800000, 3'd0, 4'd0, 1'b0};
    vecs[1] = '{32'h00000000, 3'd1, 4'd2, 1'b1};
    vecs[2] = '{32'h80000000, 3'd1, 4'd2, 1'b1};
    vecs[3] = '{32'h00000001, 3'd2, 4'd0, 1'b0};
    vecs[4] = '{32'h7F800000, 3'd3, 4'd1, 1'b1};
    vecs[5] = '{32'hFF800000, 3'd3, 4'd0, 1'b0};
    vecs[6] = '{32'h7FC00000, 3'd4, 4'd3, 1'b1};
    vecs[7] = '{32'h7F800001, 3'd5, 4'd3, 1'b1};
    exp_rdy = '{1, 1, 0, 0, 0, 1};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
    m_ready = 1'b1; cnt_clr = 1'b0;
    tick();
    tick();
    check("rst m_valid", 64'(m_valid), 64'd0);
    check("rst m_data", 64'(m_data), 64'd0);
    check("rst m_class", 64'(m_class), 64'd0);
    check("rst m_rom_addr", 64'(m_rom_addr), 64'd0);
    check("rst m_subst", 64'(m_subst), 64'd0);
    check("rst m_sign", 64'(m_sign), 64'd0);
    check("rst counters", {cnt_nan, cnt_inf, cnt_zero}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready after release", 64'(s_ready), 64'd1);
    #6;

    // directed class table, one op at a time
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = vecs[i].data;
      tick();
      s_valid = 1'b0;
      check($sformatf("t1[%0d] latency1", i), 64'(m_valid), 64'd0);
      tick();
      check($sformatf("t1[%0d] m_valid", i), 64'(m_valid), 64'd1);
      check($sformatf("t1[%0d] data", i), 64'(m_data), 64'(vecs[i].data));
      check($sformatf("t1[%0d] class", i), 64'(m_class), 64'(vecs[i].cls));
      check($sformatf("t1[%0d] addr", i), 64'(m_rom_addr), 64'(vecs[i].addr));
      check($sformatf("t1[%0d] subst", i), 64'(m_subst), 64'(vecs[i].subst));
      check($sformatf("t1[%0d] sign", i), 64'(m_sign), 64'(vecs[i].data[31]));
    end
    tick();
    check("t1 cnt_zero", 64'(cnt_zero), 64'd2);
    check("t1 cnt_inf", 64'(cnt_inf), 64'd2);
    check("t1 cnt_nan", 64'(cnt_nan), 64'd2);
    check("t1 ftz cnt_zero", 64'(f_cnt_zero), 64'd3);

    // FTZ instance flushes the smallest subnormal
    s_valid = 1'b1;
    s_data  = 32'h00000001;
    tick();
    s_valid = 1'b0;
    tick();
    check("t4 ftz class", 64'(f_m_class), 64'd1);
    check("t4 ftz subst", 64'(f_m_subst), 64'd1);
    check("t4 ftz addr", 64'(f_m_rom_addr), 64'd2);
    check("t4 default class", 64'(m_class), 64'd2);
    tick();
    check("t4 ftz cnt_zero", 64'(f_cnt_zero), 64'd4);
    check("t4 default cnt_zero", 64'(cnt_zero), 64'd2);

    // 100 back-to-back ops at full throughput
    for (int i = 0; i < 102; i++) begin
      @(posedge clk);
      #1;
      s_valid = (i < 100);
      s_data  = 32'h40000000 + 32'(i * 3);
      @(negedge clk);
      if (i < 100)
        check($sformatf("t2 s_ready[%0d]", i), 64'(s_ready), 64'd1);
      if (i >= 2) begin
        check($sformatf("t2 m_valid[%0d]", i), 64'(m_valid), 64'd1);
        check($sformatf("t2 m_data[%0d]", i), 64'(m_data),
              64'(32'h40000000 + 32'((i - 2) * 3)));
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    tick();
    tick();

    // downstream stall for 5 cycles with the stream running
    sent = 0;
    rcvd = 0;
    exp_q.delete();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      m_ready = (c >= 5);
      s_valid = (sent < 8);
      s_data  = 32'h3F000000 | 32'(sent);
      @(negedge clk);
      if (c < 6)
        check($sformatf("t3 s_ready[%0d]", c), 64'(s_ready), 64'(exp_rdy[c]));
      if (c >= 2 && c <= 4) begin
        check($sformatf("t3 hold valid[%0d]", c), 64'(m_valid), 64'd1);
        check($sformatf("t3 hold data[%0d]", c), 64'(m_data), 64'h3F000000);
      end
      if (m_valid && m_ready) begin
        got = m_data;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check($sformatf("t3 order[%0d]", rcvd), 64'(got), 64'(want));
        rcvd++;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data);
        sent++;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    check("t3 received", 64'(rcvd), 64'd8);
    check("t3 queue empty", 64'(exp_q.size()), 64'd0);
    tick();
    tick();

    // narrow counter saturation, then clear racing an accept
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("t5 cleared", 64'(c_cnt_nan), 64'd0);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = (i % 2 == 0) ? 32'h7FC00000 : 32'h7F800001;
      tick();
    end
    s_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t5 sat cnt_nan", 64'(c_cnt_nan), 64'd3);
    check("t5 wide cnt_nan", 64'(cnt_nan), 64'd5);
    s_valid = 1'b1;
    s_data  = 32'h7FC00000;
    tick();
    s_valid = 1'b0;
    tick();
    check("t5 nan at output", 64'(m_valid), 64'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("t5 clr priority narrow", 64'(c_cnt_nan), 64'd0);
    check("t5 clr priority wide", 64'(cnt_nan), 64'd0);
    tick();
    check("t5 stays clear", 64'(cnt_nan), 64'd0);

    // reset with two operands in flight
    s_valid = 1'b1;
    s_data  = 32'h00000000;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    check("t6 pre cnt_zero", 64'(cnt_zero), 64'd1);
    s_valid = 1'b1;
    s_data  = 32'h7FC00000;
    tick();
    s_data  = 32'h7F800000;
    tick();
    s_valid = 1'b0;
    rst_n   = 1'b0;
    check("t6 in flight", 64'(m_valid), 64'd1);
    tick();
    check("t6 m_valid", 64'(m_valid), 64'd0);
    check("t6 m_data", 64'(m_data), 64'd0);
    check("t6 counters", {cnt_nan, cnt_inf, cnt_zero}, 64'd0);
    check("t6 narrow counters", {c_cnt_nan, c_cnt_inf, c_cnt_zero}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6 s_ready", 64'(s_ready), 64'd1);
    tick();
    check("t6 no replay 1", 64'(m_valid), 64'd0);
    tick();
    check("t6 no replay 2", 64'(m_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
